// File: rtl/adder_pipe_n_if.sv
// adder_pipe_n_if: operand/result handshake bundle
// master drives operands, slave is the adder
interface adder_pipe_n_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_n.sv
// adder_pipe_n: pipelined ripple adder, one CHUNK slice per stage
// global stall: every stage holds while the output is blocked
module adder_pipe_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk1,
  input logic         rst_n,
  adder_pipe_n_if.slave io
);
  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad
    $error("adder_pipe_n: WIDTH must be a multiple of CHUNK");
  end

  logic stall;
  logic adv;
  logic out_vld;

  // a blocked output freezes the whole pipe
  always_comb begin
    stall = out_vld && !io.out_ready;
    adv   = !stall;
  end

  assign io.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int R = WIDTH - k * CHUNK;
    localparam int L = k * CHUNK;

    logic             sv;
    logic             sc;
    logic [R-1:0]     ra;
    logic [R-1:0]     rb;
    logic [L-1+1:0]   s_lo_dummy;
    logic             ld;
    logic [CHUNK:0]   t;
    logic [L+CHUNK-1:0] s_new;
    logic             vld_d, vld_q;
    logic             c_d, c_q;
    logic [L+CHUNK-1:0] s_d, s_q;

    assign s_lo_dummy = '0;

    if (k == 0) begin : g_src
      assign sv    = io.in_valid;
      assign ra    = io.a;
      assign rb    = io.b;
      assign sc    = io.cin;
      assign s_new = t[CHUNK-1:0];
    end else begin : g_src
      assign sv    = g_st[k-1].vld_q;
      assign ra    = g_st[k-1].g_up.a_q;
      assign rb    = g_st[k-1].g_up.b_q;
      assign sc    = g_st[k-1].c_q;
      assign s_new = {t[CHUNK-1:0], g_st[k-1].s_q};
    end

    // add this slice; load only on advance with valid data
    always_comb begin
      t = {1'b0, ra[CHUNK-1:0]}
        + {1'b0, rb[CHUNK-1:0]}
        + (CHUNK+1)'(sc);
      ld    = adv && sv;
      vld_d = adv ? sv : vld_q;
      c_d   = ld ? t[CHUNK] : c_q;
      s_d   = ld ? s_new : s_q;
    end

    // stage valid, carry and finished low sum slices
    always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        s_q   <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [R-CHUNK-1:0] a_d, a_q;
      logic [R-CHUNK-1:0] b_d, b_q;

      // carry forward the operand slices not yet added
      always_comb begin
        a_d = ld ? ra[R-1:CHUNK] : a_q;
        b_d = ld ? rb[R-1:CHUNK] : b_q;
      end

      // upper operand registers
      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      // carry into msb xor carry out of msb
      always_comb begin
        ovf_d = ld ? (ra[R-1] ^ rb[R-1]
                    ^ t[CHUNK-1] ^ t[CHUNK])
                   : ovf_q;
      end

      // registered signed overflow
      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign out_vld      = g_st[STAGES-1].vld_q;
  assign io.out_valid = out_vld;
  assign io.sum       = g_st[STAGES-1].s_q;
  assign io.cout      = g_st[STAGES-1].c_q;
  assign io.ovf       = g_st[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_adder_pipe_n.sv
// tb_adder_pipe_n: random and directed checks
// against an arithmetic reference queue
module tb_adder_pipe_n;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic clk1;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;

  logic [17:0] q[$];
  int          out_cyc[$];

  adder_pipe_n_if #(.WIDTH(WIDTH)) ifc ();

  adder_pipe_n #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .io   (ifc)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c);
    logic [16:0] full;
    logic [15:0] s;
    logic        v;
    full = 17'(a) + 17'(b) + 17'(c);
    s    = full[15:0];
    v    = (a[15] == b[15]) && (s[15] != a[15]);
    return {full[16], v, s};
  endfunction

  task automatic step();
    logic [17:0] e;
    #1;
    if (ifc.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious", 32'd1, 32'd0);
      end else begin
        e = q[0];
        chk("res", {14'd0, ifc.cout, ifc.ovf, ifc.sum},
            {14'd0, e});
      end
    end
    if (ifc.out_valid && ifc.out_ready
        && q.size() != 0) begin
      void'(q.pop_front());
      out_cyc.push_back(cyc);
    end
    if (ifc.in_valid && ifc.in_ready)
      q.push_back(model(ifc.a, ifc.b, ifc.cin));
    @(posedge clk1);
    @(negedge clk1);
    cyc++;
  endtask

  task automatic drain();
    int n;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || ifc.out_valid) && n < 40) begin
      step();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic single_op(input logic [15:0] a,
                           input logic [15:0] b,
                           input logic        c,
                           input logic [17:0] want,
                           input string       tag);
    int n;
    ifc.a         = a;
    ifc.b         = b;
    ifc.cin       = c;
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    n = 1;
    #1;
    while (!ifc.out_valid && n < 20) begin
      step();
      n++;
      #1;
    end
    chk({tag, "_lat"}, n, STAGES);
    chk(tag, {14'd0, ifc.cout, ifc.ovf, ifc.sum},
        {14'd0, want});
    step();
  endtask

  initial begin
    int   s0;
    int   nin;
    logic seen;
    logic [15:0] held;

    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
    ifc.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", ifc.out_valid, 0);
    chk("rst_sum", ifc.sum, 0);
    chk("rst_cout", ifc.cout, 0);
    chk("rst_ovf", ifc.ovf, 0);
    chk("rst_rdy", ifc.in_ready, 1);
    @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;

    single_op(16'hFFFF, 16'h0001, 1'b0, 18'h20000, "wrap");
    single_op(16'h7FFF, 16'h0000, 1'b1, 18'h18000, "sovf");
    single_op(16'h1234, 16'h4321, 1'b0, 18'h05555, "plain");
    chk("xfree", 32'($isunknown({ifc.sum, ifc.cout,
                                 ifc.ovf})), 0);

    out_cyc.delete();
    s0 = cyc;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifc.a        = 16'(i);
      ifc.b        = 16'(32'h1000 * i);
      ifc.cin      = 1'b0;
      ifc.in_valid = 1'b1;
      step();
    end
    drain();
    chk("strm_n", out_cyc.size(), 8);
    for (int j = 0; j < 8 && j < out_cyc.size(); j++)
      chk("strm_cyc", out_cyc[j], s0 + STAGES + j);

    ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.a        = 16'($urandom);
      ifc.b        = 16'($urandom);
      ifc.cin      = 1'($urandom);
      ifc.in_valid = 1'b1;
      step();
    end
    ifc.a = 16'hAAAA;
    ifc.b = 16'h5555;
    #1;
    held = ifc.sum;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_vld", ifc.out_valid, 1);
      chk("bp_rdy", ifc.in_ready, 0);
      chk("bp_sum", ifc.sum, held);
      step();
    end
    out_cyc.delete();
    s0 = cyc;
    ifc.out_ready = 1'b1;
    step();
    drain();
    chk("bp_n", out_cyc.size(), 5);
    for (int j = 0; j < 5 && j < out_cyc.size(); j++)
      chk("bp_cyc", out_cyc[j], s0 + j);

    for (int r = 0; r < 2; r++) begin
      nin = (r == 0) ? 2 : 4;
      ifc.out_ready = 1'b0;
      for (int i = 0; i < nin; i++) begin
        ifc.a        = 16'($urandom);
        ifc.b        = 16'($urandom);
        ifc.cin      = 1'($urandom);
        ifc.in_valid = 1'b1;
        step();
      end
      ifc.in_valid = 1'b0;
      #1;
      chk("rst_pre", ifc.out_valid, (nin == 4) ? 1 : 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_vld", ifc.out_valid, 0);
      chk("rst_mid_rdy", ifc.in_ready, 1);
      q.delete();
      @(posedge clk1);
      @(negedge clk1);
      rst_n = 1'b1;
      ifc.out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        seen = seen | ifc.out_valid;
        step();
      end
      chk("rst_ghost", seen, 0);
    end

    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = ($urandom_range(3) != 0);
      ifc.a         = 16'($urandom);
      ifc.b         = 16'($urandom);
      ifc.cin       = 1'($urandom);
      ifc.out_ready = ($urandom_range(9) < 7);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
